// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus between fetch and imem
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch front end with redirect squash
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          SEL_PC_WIDTH = 2,
    parameter logic [31:0] NOP          = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_stall,
    input  logic [SEL_PC_WIDTH-1:0] pc_sel,
    input  logic                    br_taken,
    input  logic [31:0]             next_pc,
    fetch_unit_if.master            imem,
    output logic                    valid,
    output logic [31:0]             ir,
    output logic [31:0]             pc
);

    localparam logic [SEL_PC_WIDTH-1:0] SEL_BRANCH = SEL_PC_WIDTH'(1);
    localparam logic [SEL_PC_WIDTH-1:0] SEL_JUMP   = SEL_PC_WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_KILL = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        redirect;
    logic [31:0] target;
    logic        consumed;

    // Redirect decode from control; targets are forced to word alignment.
    always_comb begin
        redirect = ((pc_sel == SEL_BRANCH) && br_taken) || (pc_sel == SEL_JUMP);
        target   = {next_pc[31:2], 2'b00};
        consumed = valid && !fetch_stall;
    end

    // Request is a pure decode of registered state, so imem inputs never reach it combinationally.
    assign imem.req  = (state == S_REQ);
    assign imem.addr = pc_q;

    // Fetch FSM: owns pc_q and the registered decode-facing outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            pc_q  <= RESET_PC;
            valid <= 1'b0;
            ir    <= NOP;
            pc    <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (redirect) begin
                        // A response landing with the redirect is stale; otherwise it is still owed.
                        pc_q  <= target;
                        valid <= 1'b0;
                        state <= imem.rvalid ? S_REQ : S_KILL;
                    end else if (imem.rvalid) begin
                        ir    <= imem.rdata;
                        pc    <= pc_q;
                        valid <= 1'b1;
                        pc_q  <= pc_q + 32'd4;
                        state <= fetch_stall ? S_HOLD : S_REQ;
                    end else if (consumed) begin
                        valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        valid <= 1'b0;
                        pc_q  <= target;
                        state <= S_REQ;
                    end else if (!fetch_stall) begin
                        // Decode takes the held instruction this cycle.
                        valid <= 1'b0;
                        state <= S_REQ;
                    end
                end
                S_KILL: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    if (imem.rvalid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
